data_array_evict_reader: RTL and testbench
==========================================

Name: data_array_evict_reader

Overview:
- Read-side client of the cache data array: takes eviction/writeback requests (set, way, half-mask, id) and issues one data-array read through a shared, arbitrated read port.
- Captures the 256-bit line on the cycle after the grant.
- Serialises the selected 128-bit halves onto a valid/ready stream toward the memory-side writeback path.
- Sits between the replacement/miss-handling logic and the memory interface.

Parameters:
SET_W, 6, width of set index (matches data array setWidth_t)
WAY_W, 2, width of way index (4 ways)
ID_W, 4, width of request id passed through to output beats

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  eviction request valid
req_ready  out  1  block can accept request (high only in IDLE)
req_set  in  SET_W  set to read
req_way  in  WAY_W  way to read
req_mask  in  2  halves to send: bit0 = data[127:0], bit1 = data[255:128]
req_id  in  ID_W  request tag
rd_en  out  1  data array read enable (request to read-port arbiter)
rd_gnt  in  1  arbiter grant; read issues on rd_en & rd_gnt
rd_set  out  SET_W  read set
rd_way  out  WAY_W  read way
rd_mask  out  2  read mask (latched req_mask)
rd_data  in  256  data array read data, valid exactly 1 cycle after issue
out_valid  out  1  beat valid
out_ready  in  1  beat accepted
out_data  out  128  beat data
out_half  out  1  which half this beat carries
out_last  out  1  final beat of request
out_id  out  ID_W  latched req_id
evict_done  out  1  one-cycle pulse, request complete

Behaviour:
- FSM states: IDLE, RD, CAP, SEND.
- Reset (async, rst=1): state=IDLE; all outputs 0 except req_ready=1; line buffer and latched fields cleared. Reset mid-operation aborts silently: no beat, no evict_done.
- IDLE: req_ready=1. On req_valid: latch set/way/mask/id.
  - mask!=0 -> RD.
  - mask==0 -> stay IDLE, evict_done=1 next cycle, no read, no beats.
- RD: rd_en=1; rd_set/rd_way/rd_mask = latched values, held stable until granted. rd_gnt=1 -> CAP; else stay.
- CAP: rd_data is valid this cycle. Capture it into the 256-bit buffer; set half index to lowest set mask bit; -> SEND.
- SEND: out_valid=1.
  - out_data = buffer half[idx]; out_half=idx; out_id=latched id.
  - out_last=1 if no mask bit above idx is set.
  - out_ready=0: hold all out_* stable.
  - out_ready=1 and !out_last: idx=1, stay SEND.
  - out_ready=1 and out_last: -> IDLE, evict_done=1 next cycle.
- rd_data outside CAP is ignored. rd_en=0 in every state except RD.
- evict_done is registered, high exactly 1 cycle; it coincides with the IDLE cycle in which req_ready=1.
- Minimum latency (gnt and ready held high):
  - accept at cycle 0, rd_en at 1, capture at 2, first beat at 3;
  - second beat at 4 for mask 2'b11; evict_done the cycle after the last handshake.
- Throughput: one request in flight; a new request can be accepted in the same cycle evict_done is high.
- Mask 2'b10: single beat, out_half=1, out_last=1. Mask 2'b01: single beat, out_half=0, out_last=1.

Test Plan:
- Basic full line: set=5, way=2, mask=11, id=3, rd_data={128'hB..B, 128'hA..A}, gnt and ready always 1. Required: rd_en high exactly 1 cycle with rd_set=5, rd_way=2; beats A (half0, last=0) then B (half1, last=1), both id=3; evict_done 1 cycle later.
- Grant stall: rd_gnt low 4 cycles. Required: rd_en and rd_set/rd_way/rd_mask held stable for 5 cycles; capture only on the cycle after the grant. rd_data changing during the stall must not leak into beats.
- Backpressure: mask=11, out_ready low 3 cycles on beat 0 then high. Required: beat 0 stable for 4 cycles, then beat 1; exactly 2 handshakes total.
- Partial masks: mask=10 gives one beat, half=1, last=1. mask=01 gives one beat, half=0, last=1. mask=00 gives no rd_en, no beats, and evict_done the cycle after accept.
- Reset mid-SEND: assert rst while beat 0 is stalled. Required: out_valid=0 and req_ready=1 immediately (async); no evict_done. A new request then completes normally.
- Back-to-back: second request presented with req_valid held high. Required: accepted in the same cycle evict_done is high for the first request; req_ready=0 throughout RD/CAP/SEND.

Source files
------------

// File: rtl/data_array_evict_reader_if.sv
// ---------------------------------------------------------------------------
// data_array_evict_reader_if
// Bundles the three handshakes of the eviction reader:
//   req_*   : eviction request from replacement/miss logic (valid/ready)
//   rd_*    : shared data-array read port (enable/grant, data 1 cycle later)
//   out_*   : 128-bit writeback beat stream (valid/ready) + evict_done pulse
// Modports:
//   master : the eviction reader itself (drives req_ready, rd_*, out_*)
//   slave  : its environment (requester, arbiter/array, writeback sink)
// ---------------------------------------------------------------------------
interface data_array_evict_reader_if #(
  parameter int SET_W = 6,
  parameter int WAY_W = 2,
  parameter int ID_W  = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [SET_W-1:0] req_set;
  logic [WAY_W-1:0] req_way;
  logic [1:0]       req_mask;
  logic [ID_W-1:0]  req_id;

  logic             rd_en;
  logic             rd_gnt;
  logic [SET_W-1:0] rd_set;
  logic [WAY_W-1:0] rd_way;
  logic [1:0]       rd_mask;
  logic [255:0]     rd_data;

  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_half;
  logic             out_last;
  logic [ID_W-1:0]  out_id;
  logic             evict_done;

  modport master (
    input  req_valid, req_set, req_way, req_mask, req_id,
    input  rd_gnt, rd_data,
    input  out_ready,
    output req_ready,
    output rd_en, rd_set, rd_way, rd_mask,
    output out_valid, out_data, out_half, out_last, out_id, evict_done
  );

  modport slave (
    output req_valid, req_set, req_way, req_mask, req_id,
    output rd_gnt, rd_data,
    output out_ready,
    input  req_ready,
    input  rd_en, rd_set, rd_way, rd_mask,
    input  out_valid, out_data, out_half, out_last, out_id, evict_done
  );
endinterface

// File: rtl/data_array_evict_reader.sv
// ---------------------------------------------------------------------------
// data_array_evict_reader
// Read-side client of the cache data array. Accepts one eviction request at
// a time, issues a single arbitrated read of the 256-bit line, captures it
// the cycle after the grant and streams the selected 128-bit halves (low
// half first) toward the writeback path. evict_done pulses for one cycle
// once the last beat is accepted (or right after a request with no halves).
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high; aborts any request silently
//   bus  : data_array_evict_reader_if.master (req_*, rd_*, out_*, evict_done)
// ---------------------------------------------------------------------------
module data_array_evict_reader #(
  parameter int SET_W = 6,
  parameter int WAY_W = 2,
  parameter int ID_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  data_array_evict_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] set_q;
  logic [WAY_W-1:0] way_q;
  logic [1:0]       mask_q;
  logic [ID_W-1:0]  id_q;
  logic [255:0]     line_q;
  logic             half_q;
  logic             done_q;

  logic             req_ready_c;
  logic             rd_en_c;
  logic             out_valid_c;
  logic             last_c;
  logic             accept_c;
  logic             beat_hs_c;

  // Current half is the last one when it is the upper half or the upper
  // half was not requested.
  assign last_c    = half_q | ~mask_q[1];
  assign accept_c  = (state_q == IDLE) & bus.req_valid;
  assign beat_hs_c = (state_q == SEND) & bus.out_ready;

  // NOTE: state register and next-state logic are split; the register is the
  // only place the state changes, so reset and clocking stay in one spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    rd_en_c     = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        // An empty mask completes without touching the array.
        if (bus.req_valid && (bus.req_mask != 2'b00)) state_d = RD;
      end
      RD: begin
        rd_en_c = 1'b1;
        if (bus.rd_gnt) state_d = CAP;
      end
      CAP: state_d = SEND;
      SEND: begin
        out_valid_c = 1'b1;
        if (bus.out_ready && last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line buffer is reset along with the control state so outputs
  // read as zero after reset; sequential state uses non-blocking updates
  // only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q  <= '0;
      way_q  <= '0;
      mask_q <= '0;
      id_q   <= '0;
      line_q <= '0;
      half_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (accept_c && (bus.req_mask == 2'b00)) || (beat_hs_c && last_c);
      if (accept_c) begin
        set_q  <= bus.req_set;
        way_q  <= bus.req_way;
        mask_q <= bus.req_mask;
        id_q   <= bus.req_id;
      end
      if (state_q == CAP) begin
        // rd_data is only meaningful here; start at the lowest requested half.
        line_q <= bus.rd_data;
        half_q <= ~mask_q[0];
      end else if (beat_hs_c && !last_c) begin
        half_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rd_en      = rd_en_c;
  assign bus.rd_set     = set_q;
  assign bus.rd_way     = way_q;
  assign bus.rd_mask    = mask_q;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = half_q ? line_q[255:128] : line_q[127:0];
  assign bus.out_half   = half_q;
  assign bus.out_last   = (state_q == SEND) & last_c;
  assign bus.out_id     = id_q;
  assign bus.evict_done = done_q;

endmodule

// File: tb/tb_data_array_evict_reader.sv
// ---------------------------------------------------------------------------
// tb_data_array_evict_reader
// Directed bench for data_array_evict_reader. Inputs change 1 ns after the
// rising edge, immediately after outputs for that cycle are sampled.
// ---------------------------------------------------------------------------
module tb_data_array_evict_reader;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_bad;

  data_array_evict_reader_if #(.SET_W(6), .WAY_W(2), .ID_W(4)) bus ();

  data_array_evict_reader #(.SET_W(6), .WAY_W(2), .ID_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] HALF_A = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] HALF_B = {4{32'hBBBB_BBBB}};
  localparam logic [127:0] HALF_C = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] HALF_D = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
  localparam logic [255:0] JUNK   = {8{32'hDEAD_BEEF}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [5:0] s, input logic [1:0] w,
                           input logic [1:0] m, input logic [3:0] id);
    bus.req_valid = 1'b1;
    bus.req_set   = s;
    bus.req_way   = w;
    bus.req_mask  = m;
    bus.req_id    = id;
  endtask

  // One request at minimum latency (grant and ready held high), starting in
  // an IDLE cycle; checks read issue, every beat and the done pulse.
  task automatic run_req(input string tag, input logic [5:0] s, input logic [1:0] w,
                         input logic [1:0] m, input logic [3:0] id, input logic [255:0] line);
    check({tag, " idle ready"}, bus.req_ready, 1'b1);
    drive_req(s, w, m, id);
    bus.rd_gnt    = 1'b1;
    bus.out_ready = 1'b1;
    bus.rd_data   = JUNK;
    tick();
    bus.req_valid = 1'b0;
    if (m == 2'b00) begin
      check({tag, " no rd_en"}, bus.rd_en, 1'b0);
      check({tag, " no beat"}, bus.out_valid, 1'b0);
      check({tag, " done"}, bus.evict_done, 1'b1);
      tick();
      check({tag, " done once"}, bus.evict_done, 1'b0);
      check({tag, " still no rd_en"}, bus.rd_en, 1'b0);
      return;
    end
    check({tag, " rd_en"}, bus.rd_en, 1'b1);
    check({tag, " rd_set"}, bus.rd_set, s);
    check({tag, " rd_way"}, bus.rd_way, w);
    check({tag, " rd_mask"}, bus.rd_mask, m);
    check({tag, " busy"}, bus.req_ready, 1'b0);
    tick();
    check({tag, " rd_en one cycle"}, bus.rd_en, 1'b0);
    check({tag, " no beat in cap"}, bus.out_valid, 1'b0);
    bus.rd_data = line;
    tick();
    bus.rd_data = ~line;
    for (int h = 0; h < 2; h++) begin
      if (m[h]) begin
        check({tag, " beat valid"}, bus.out_valid, 1'b1);
        check({tag, " beat data"}, bus.out_data, (h == 1) ? line[255:128] : line[127:0]);
        check({tag, " beat half"}, bus.out_half, h[0]);
        check({tag, " beat last"}, bus.out_last, (h == 1) || !m[1]);
        check({tag, " beat id"}, bus.out_id, id);
        check({tag, " no early done"}, bus.evict_done, 1'b0);
        tick();
      end
    end
    check({tag, " beats over"}, bus.out_valid, 1'b0);
    check({tag, " done"}, bus.evict_done, 1'b1);
    check({tag, " ready at done"}, bus.req_ready, 1'b1);
    tick();
    check({tag, " done once"}, bus.evict_done, 1'b0);
  endtask

  initial begin
    int hs;
    n_checks = 0;
    n_bad    = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_set    = '0;
    bus.req_way    = '0;
    bus.req_mask   = '0;
    bus.req_id     = '0;
    bus.rd_gnt     = 1'b0;
    bus.rd_data    = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst req_ready", bus.req_ready, 1'b1);
    check("rst rd_en", bus.rd_en, 1'b0);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_last", bus.out_last, 1'b0);
    check("rst evict_done", bus.evict_done, 1'b0);
    check("rst rd_set", bus.rd_set, 6'd0);
    check("rst out_data", bus.out_data, 128'd0);
    check("rst out_id", bus.out_id, 4'd0);

    // Basic full line and partial masks
    run_req("basic", 6'd5, 2'd2, 2'b11, 4'd3, {HALF_B, HALF_A});
    run_req("mask10", 6'd17, 2'd1, 2'b10, 4'd9, {HALF_D, HALF_C});
    run_req("mask01", 6'd63, 2'd3, 2'b01, 4'd14, {HALF_A, HALF_D});
    run_req("mask00", 6'd8, 2'd0, 2'b00, 4'd6, {HALF_B, HALF_C});

    // Grant stall: rd_gnt low 4 cycles, rd_data churning meanwhile
    drive_req(6'd9, 2'd1, 2'b11, 4'd7);
    bus.rd_gnt    = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall rd_en", bus.rd_en, 1'b1);
      check("stall rd_set", bus.rd_set, 6'd9);
      check("stall rd_way", bus.rd_way, 2'd1);
      check("stall rd_mask", bus.rd_mask, 2'b11);
      check("stall no beat", bus.out_valid, 1'b0);
      bus.rd_data = {8{i[3:0], 28'h5A5A_5A5}};
      if (i == 4) bus.rd_gnt = 1'b1;
      tick();
    end
    check("stall cap rd_en", bus.rd_en, 1'b0);
    bus.rd_data = {HALF_D, HALF_C};
    tick();
    bus.rd_data = JUNK;
    check("stall beat0 data", bus.out_data, HALF_C);
    check("stall beat0 half", bus.out_half, 1'b0);
    tick();
    check("stall beat1 data", bus.out_data, HALF_D);
    check("stall beat1 last", bus.out_last, 1'b1);
    tick();
    check("stall done", bus.evict_done, 1'b1);
    tick();

    // Backpressure: out_ready low for 3 cycles on beat 0
    drive_req(6'd12, 2'd3, 2'b11, 4'd5);
    bus.rd_gnt    = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.rd_data = {HALF_A, HALF_D};
    tick();
    bus.rd_data = JUNK;
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      check("bp beat0 valid", bus.out_valid, 1'b1);
      check("bp beat0 data", bus.out_data, HALF_D);
      check("bp beat0 half", bus.out_half, 1'b0);
      check("bp beat0 last", bus.out_last, 1'b0);
      if (i == 3) bus.out_ready = 1'b1;
      if (bus.out_valid && bus.out_ready) hs++;
      tick();
    end
    check("bp beat1 data", bus.out_data, HALF_A);
    check("bp beat1 half", bus.out_half, 1'b1);
    check("bp beat1 last", bus.out_last, 1'b1);
    if (bus.out_valid && bus.out_ready) hs++;
    tick();
    check("bp done", bus.evict_done, 1'b1);
    if (bus.out_valid && bus.out_ready) hs++;
    check("bp handshakes", hs, 2);
    tick();

    // Reset while beat 0 is stalled
    drive_req(6'd33, 2'd2, 2'b11, 4'd11);
    bus.out_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.rd_data = {HALF_C, HALF_B};
    tick();
    tick();
    check("mid beat stalled", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid async out_valid", bus.out_valid, 1'b0);
    check("mid async req_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid no done", bus.evict_done, 1'b0);
      check("mid no beat", bus.out_valid, 1'b0);
    end
    run_req("after rst", 6'd21, 2'd0, 2'b01, 4'd2, {HALF_A, HALF_C});

    // Back-to-back with req_valid held high
    drive_req(6'd1, 2'd1, 2'b01, 4'd1);
    bus.rd_gnt    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    drive_req(6'd2, 2'd2, 2'b10, 4'd2);
    check("b2b rd busy", bus.req_ready, 1'b0);
    tick();
    check("b2b cap busy", bus.req_ready, 1'b0);
    bus.rd_data = {HALF_B, HALF_D};
    tick();
    check("b2b send busy", bus.req_ready, 1'b0);
    check("b2b first data", bus.out_data, HALF_D);
    check("b2b first id", bus.out_id, 4'd1);
    tick();
    check("b2b done", bus.evict_done, 1'b1);
    check("b2b accept ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    check("b2b second rd_en", bus.rd_en, 1'b1);
    check("b2b second rd_set", bus.rd_set, 6'd2);
    tick();
    bus.rd_data = {HALF_C, HALF_A};
    tick();
    check("b2b second data", bus.out_data, HALF_C);
    check("b2b second half", bus.out_half, 1'b1);
    check("b2b second last", bus.out_last, 1'b1);
    check("b2b second id", bus.out_id, 4'd2);
    tick();
    check("b2b second done", bus.evict_done, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
